// File: rtl/ram_1w2r_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ram_1w2r_pipe
// Description : Single-clock RAM with one instruction read port (32-bit lane
//               fetch) and one data read/write port. Each port returns its
//               response one cycle after acceptance through a one-entry
//               response register with ready/valid backpressure.
//               DATA_W must be 64 or 128.
//               Build option: define RAM_1W2R_BYPASS_EN for write-first
//               behaviour when an inst read and a data write hit the same
//               word in the same cycle; otherwise the inst read is read-first.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_1w2r_pipe #(
  parameter int          DATA_W     = 64,
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000
) (
  input  logic                clk,
  input  logic                rst,

  // Instruction fetch port (read only)
  input  logic                inst_valid,
  input  logic [63:0]         inst_addr,
  input  logic                inst_rsp_ready,
  output logic                inst_ready,
  output logic                inst_rsp_valid,
  output logic [31:0]         inst,
  output logic                inst_err,

  // Data port (read / masked write)
  input  logic                ram_valid,
  input  logic                ram_w_ena,
  input  logic [63:0]         ram_addr,
  input  logic [DATA_W-1:0]   ram_w_data,
  input  logic [DATA_W/8-1:0] ram_w_mask,
  input  logic                ram_rsp_ready,
  output logic                ram_ready,
  output logic                ram_rsp_valid,
  output logic [DATA_W-1:0]   ram_r_data,
  output logic                ram_err
);

  localparam int WORD_BYTES = DATA_W / 8;
  localparam int OFF_W      = $clog2(WORD_BYTES);
  localparam int LANE_W     = OFF_W - 2;
  localparam int HI         = OFF_W + DEPTH_LOG2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  // --------------------------------------------------------------------------
  // Storage (never reset: contents survive rst)
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Address decode. The subtraction is a full 64-bit wrap, so anything below
  // BASE_ADDR lands far above the window and is flagged out of range.
  // --------------------------------------------------------------------------
  logic [63:0]           w_inst_off;
  logic [63:0]           w_ram_off;
  logic                  w_inst_in_range;
  logic                  w_ram_in_range;
  logic [DEPTH_LOG2-1:0] w_inst_idx;
  logic [DEPTH_LOG2-1:0] w_ram_idx;
  logic [LANE_W-1:0]     w_inst_lane;
  logic                  w_unused;

  assign w_inst_off      = inst_addr - BASE_ADDR;
  assign w_ram_off       = ram_addr - BASE_ADDR;
  assign w_inst_in_range = (w_inst_off[63:HI] == '0);
  assign w_ram_in_range  = (w_ram_off[63:HI] == '0);
  assign w_inst_idx      = w_inst_off[HI-1:OFF_W];
  assign w_ram_idx       = w_ram_off[HI-1:OFF_W];
  // Lane select comes straight from the request address bits.
  assign w_inst_lane     = inst_addr[OFF_W-1:2];
  // Byte-offset bits of the offset are intentionally not used for indexing.
  assign w_unused        = ^{w_inst_off[OFF_W-1:0], w_ram_off[OFF_W-1:0]};

  // --------------------------------------------------------------------------
  // Handshake. A port can accept when its response slot is empty or is being
  // drained this cycle; nothing is accepted while rst is high.
  // --------------------------------------------------------------------------
  logic inst_rsp_valid_q;
  logic inst_rsp_valid_d;
  logic ram_rsp_valid_q;
  logic ram_rsp_valid_d;
  logic w_inst_fire;
  logic w_ram_fire;
  logic w_wr_fire;

  assign inst_ready  = !rst && (!inst_rsp_valid_q || inst_rsp_ready);
  assign ram_ready   = !rst && (!ram_rsp_valid_q || ram_rsp_ready);
  assign w_inst_fire = inst_valid && inst_ready;
  assign w_ram_fire  = ram_valid && ram_ready;
  // Out-of-range writes are acknowledged but never touch the array.
  assign w_wr_fire   = w_ram_fire && ram_w_ena && w_ram_in_range;

  // --------------------------------------------------------------------------
  // Inst-port read word, including optional same-cycle write forwarding
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_inst_word;
  logic [31:0]       w_inst_lane_data;

  // Fetch the addressed word; in the bypass build merge a colliding write.
  always_comb begin
    w_inst_word = mem_q[w_inst_idx];
`ifdef RAM_1W2R_BYPASS_EN
    if (w_wr_fire && (w_ram_idx == w_inst_idx)) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (ram_w_mask[b]) begin
          w_inst_word[b*8 +: 8] = ram_w_data[b*8 +: 8];
        end
      end
    end
`endif
  end

  assign w_inst_lane_data = w_inst_word[{w_inst_lane, 5'b0} +: 32];

  // --------------------------------------------------------------------------
  // Inst response register
  // --------------------------------------------------------------------------
  logic [31:0] inst_q;
  logic [31:0] inst_d;
  logic        inst_err_q;
  logic        inst_err_d;

  // Load on accept, drop valid once the consumer takes it, else hold.
  always_comb begin
    inst_rsp_valid_d = inst_rsp_valid_q;
    inst_d           = inst_q;
    inst_err_d       = inst_err_q;
    if (w_inst_fire) begin
      inst_rsp_valid_d = 1'b1;
      inst_d           = w_inst_in_range ? w_inst_lane_data : 32'h0;
      inst_err_d       = !w_inst_in_range;
    end else if (inst_rsp_ready) begin
      inst_rsp_valid_d = 1'b0;
    end
  end

  // Inst response state; reset discards any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_rsp_valid_q <= 1'b0;
      inst_q           <= 32'h0;
      inst_err_q       <= 1'b0;
    end else begin
      inst_rsp_valid_q <= inst_rsp_valid_d;
      inst_q           <= inst_d;
      inst_err_q       <= inst_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Data response register
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] ram_r_data_q;
  logic [DATA_W-1:0] ram_r_data_d;
  logic              ram_err_q;
  logic              ram_err_d;

  // Reads return the full word; writes and out-of-range accesses return zero.
  always_comb begin
    ram_rsp_valid_d = ram_rsp_valid_q;
    ram_r_data_d    = ram_r_data_q;
    ram_err_d       = ram_err_q;
    if (w_ram_fire) begin
      ram_rsp_valid_d = 1'b1;
      ram_r_data_d    = (!ram_w_ena && w_ram_in_range) ? mem_q[w_ram_idx]
                                                       : '0;
      ram_err_d       = !w_ram_in_range;
    end else if (ram_rsp_ready) begin
      ram_rsp_valid_d = 1'b0;
    end
  end

  // Data response state; reset discards any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_rsp_valid_q <= 1'b0;
      ram_r_data_q    <= '0;
      ram_err_q       <= 1'b0;
    end else begin
      ram_rsp_valid_q <= ram_rsp_valid_d;
      ram_r_data_q    <= ram_r_data_d;
      ram_err_q       <= ram_err_d;
    end
  end

  // Byte-masked array write; ready is low during rst so no write can occur.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (ram_w_mask[b]) begin
          mem_q[w_ram_idx][b*8 +: 8] <= ram_w_data[b*8 +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs are forced quiet for the whole time rst is high, including the
  // first reset cycle before the registers have been cleared.
  // --------------------------------------------------------------------------
  assign inst_rsp_valid = inst_rsp_valid_q && !rst;
  assign inst           = rst ? 32'h0 : inst_q;
  assign inst_err       = inst_err_q && !rst;
  assign ram_rsp_valid  = ram_rsp_valid_q && !rst;
  assign ram_r_data     = rst ? '0 : ram_r_data_q;
  assign ram_err        = ram_err_q && !rst;

endmodule
`default_nettype wire

// File: tb/tb_ram_1w2r_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_1w2r_pipe
// Description : Directed self-checking bench for ram_1w2r_pipe (default
//               parameters, DATA_W = 64). Honours RAM_1W2R_BYPASS_EN for the
//               collision expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_1w2r_pipe;

  localparam int DW = 64;

`ifdef RAM_1W2R_BYPASS_EN
  localparam logic [31:0] EXP_COLLIDE_HI = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] EXP_COLLIDE_HI = 32'h1122_3344;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          inst_valid = 1'b0;
  logic [63:0]   inst_addr = '0;
  logic          inst_rsp_ready = 1'b1;
  logic          inst_ready;
  logic          inst_rsp_valid;
  logic [31:0]   inst;
  logic          inst_err;
  logic          ram_valid = 1'b0;
  logic          ram_w_ena = 1'b0;
  logic [63:0]   ram_addr = '0;
  logic [DW-1:0] ram_w_data = '0;
  logic [7:0]    ram_w_mask = '0;
  logic          ram_rsp_ready = 1'b1;
  logic          ram_ready;
  logic          ram_rsp_valid;
  logic [DW-1:0] ram_r_data;
  logic          ram_err;

  int n_tests = 0;
  int n_fail  = 0;

  ram_1w2r_pipe dut (
    .clk            (clk),
    .rst            (rst),
    .inst_valid     (inst_valid),
    .inst_addr      (inst_addr),
    .inst_rsp_ready (inst_rsp_ready),
    .inst_ready     (inst_ready),
    .inst_rsp_valid (inst_rsp_valid),
    .inst           (inst),
    .inst_err       (inst_err),
    .ram_valid      (ram_valid),
    .ram_w_ena      (ram_w_ena),
    .ram_addr       (ram_addr),
    .ram_w_data     (ram_w_data),
    .ram_w_mask     (ram_w_mask),
    .ram_rsp_ready  (ram_rsp_ready),
    .ram_ready      (ram_ready),
    .ram_rsp_valid  (ram_rsp_valid),
    .ram_r_data     (ram_r_data),
    .ram_err        (ram_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: present one request per port, let it be accepted on
  // the next posedge, then withdraw the requests at the following negedge.
  task automatic xact(input bit iv, input logic [63:0] ia,
                      input bit rv, input bit we, input logic [63:0] ra,
                      input logic [63:0] wd, input logic [7:0] m);
    inst_valid = iv;
    inst_addr  = ia;
    ram_valid  = rv;
    ram_w_ena  = we;
    ram_addr   = ra;
    ram_w_data = wd;
    ram_w_mask = m;
    @(posedge clk);
    @(negedge clk);
    inst_valid = 1'b0;
    ram_valid  = 1'b0;
  endtask

  task automatic dwrite(input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] m);
    xact(1'b0, 64'h0, 1'b1, 1'b1, a, d, m);
  endtask

  task automatic dread(input logic [63:0] a);
    xact(1'b0, 64'h0, 1'b1, 1'b0, a, 64'h0, 8'h00);
  endtask

  task automatic iread(input logic [63:0] a);
    xact(1'b1, a, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- Reset: outputs quiet, no accept ----------------
    @(negedge clk);
    inst_valid = 1'b1;
    inst_addr  = 64'h8000_0010;
    ram_valid  = 1'b1;
    ram_w_ena  = 1'b0;
    ram_addr   = 64'h8000_0010;
    @(negedge clk);
    check("rst_inst_ready", inst_ready, 0);
    check("rst_ram_ready", ram_ready, 0);
    check("rst_inst_rsp_valid", inst_rsp_valid, 0);
    check("rst_ram_rsp_valid", ram_rsp_valid, 0);
    check("rst_outs", {inst, inst_err, ram_err, ram_r_data}, 0);
    inst_valid = 1'b0;
    ram_valid  = 1'b0;
    rst        = 1'b0;
    #1;
    check("first_cycle_inst_ready", inst_ready, 1);
    check("first_cycle_ram_ready", ram_ready, 1);

    // ---------------- Full write and readback ----------------
    dwrite(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
    check("wr_ack_valid", ram_rsp_valid, 1);
    check("wr_ack_data", ram_r_data, 0);
    check("wr_ack_err", ram_err, 0);
    dread(64'h8000_0010);
    check("rd_valid", ram_rsp_valid, 1);
    check("rd_data", ram_r_data, 64'h1122_3344_5566_7788);
    check("rd_err", ram_err, 0);
    @(negedge clk);
    check("rsp_drained", ram_rsp_valid, 0);

    // ---------------- Partial write, lane fetch ----------------
    dwrite(64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    dread(64'h8000_0010);
    check("mask_rd_data", ram_r_data, 64'h1122_3344_AAAA_AAAA);
    iread(64'h8000_0014);
    check("inst_valid_hi", inst_rsp_valid, 1);
    check("inst_hi", inst, 32'h1122_3344);
    check("inst_err_hi", inst_err, 0);
    iread(64'h8000_0010);
    check("inst_lo", inst, 32'hAAAA_AAAA);

    // ---------------- Same-cycle collisions ----------------
    xact(1'b1, 64'h8000_0010, 1'b1, 1'b1, 64'h8000_0010,
         64'hFFFF_FFFF_0000_0000, 8'hF0);
    check("collide_lo_inst", inst, 32'hAAAA_AAAA);
    check("collide_lo_ack", ram_rsp_valid, 1);
    dwrite(64'h8000_0010, 64'h1122_3344_AAAA_AAAA, 8'hFF);
    xact(1'b1, 64'h8000_0014, 1'b1, 1'b1, 64'h8000_0010,
         64'hFFFF_FFFF_0000_0000, 8'hF0);
    check("collide_hi_inst", inst, EXP_COLLIDE_HI);
    dread(64'h8000_0013);
    check("after_collide_word", ram_r_data, 64'hFFFF_FFFF_AAAA_AAAA);

    // ---------------- Backpressure ----------------
    ram_rsp_ready = 1'b0;
    dread(64'h8000_0010);
    check("bp_valid_0", ram_rsp_valid, 1);
    check("bp_ready_0", ram_ready, 0);
    check("bp_data_0", ram_r_data, 64'hFFFF_FFFF_AAAA_AAAA);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid_hold", ram_rsp_valid, 1);
      check("bp_ready_hold", ram_ready, 0);
      check("bp_data_hold", ram_r_data, 64'hFFFF_FFFF_AAAA_AAAA);
    end
    ram_rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", ram_ready, 1);
    @(negedge clk);
    check("bp_consumed", ram_rsp_valid, 0);
    check("bp_ready_after", ram_ready, 1);

    // ---------------- Back-to-back reads ----------------
    dwrite(64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF);
    ram_valid = 1'b1;
    ram_w_ena = 1'b0;
    ram_addr  = 64'h8000_0010;
    @(posedge clk);
    @(negedge clk);
    check("b2b_first", ram_r_data, 64'hFFFF_FFFF_AAAA_AAAA);
    check("b2b_ready", ram_ready, 1);
    ram_addr = 64'h8000_0000;
    @(posedge clk);
    @(negedge clk);
    ram_valid = 1'b0;
    check("b2b_second_valid", ram_rsp_valid, 1);
    check("b2b_second", ram_r_data, 64'h0123_4567_89AB_CDEF);

    // ---------------- Out-of-range ----------------
    dread(64'h7FFF_FFF8);
    check("oor_low_data", ram_r_data, 0);
    check("oor_low_err", ram_err, 1);
    dread(64'h8000_8000);
    check("oor_high_data", ram_r_data, 0);
    check("oor_high_err", ram_err, 1);
    dwrite(64'h7FFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    check("oor_wr_err", ram_err, 1);
    check("oor_wr_data", ram_r_data, 0);
    dread(64'h8000_0000);
    check("oor_wr_word0", ram_r_data, 64'h0123_4567_89AB_CDEF);
    check("inrange_err_clear", ram_err, 0);
    dwrite(64'h8000_7FF8, 64'hCAFE_F00D_1234_5678, 8'hFF);
    check("last_word_wr_err", ram_err, 0);
    iread(64'h8000_7FFC);
    check("last_word_inst", inst, 32'hCAFE_F00D);
    check("last_word_inst_err", inst_err, 0);
    iread(64'h8000_8000);
    check("oor_inst_data", inst, 0);
    check("oor_inst_err", inst_err, 1);

    // ---------------- Reset with pending responses ----------------
    xact(1'b1, 64'h8000_0010, 1'b1, 1'b1, 64'h8000_0020,
         64'h5555_5555_5555_5555, 8'hFF);
    rst        = 1'b1;
    ram_valid  = 1'b1;
    ram_w_ena  = 1'b1;
    ram_addr   = 64'h8000_0010;
    ram_w_data = 64'h0;
    ram_w_mask = 8'hFF;
    #1;
    check("rst1_inst_rsp_valid", inst_rsp_valid, 0);
    check("rst1_ram_rsp_valid", ram_rsp_valid, 0);
    check("rst1_ready", {inst_ready, ram_ready}, 0);
    @(negedge clk);
    check("rst2_inst_rsp_valid", inst_rsp_valid, 0);
    ram_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_inst_ready", inst_ready, 1);
    check("post_rst_inst_rsp_valid", inst_rsp_valid, 0);
    @(negedge clk);
    check("post_rst_no_stale_inst", inst_rsp_valid, 0);
    check("post_rst_no_stale_ram", ram_rsp_valid, 0);
    dread(64'h8000_0020);
    check("pre_rst_write_done", ram_r_data, 64'h5555_5555_5555_5555);
    dread(64'h8000_0010);
    check("no_write_in_rst", ram_r_data, 64'hFFFF_FFFF_AAAA_AAAA);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
